jk_shift_ctrl: RTL

//  Sequencer for a WIDTH-bit shift register built from JK flip-flop cells.

---
 rtl/jk_shift_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/jk_shift_ctrl.sv
// Command sequencer for a shift register built from JK flip-flop cells.
// Steers per-bit j/k so the bank takes the target value each clock; reads q back for shifts.
module jk_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;

  logic [1:0]       state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             drive_en;
  logic [WIDTH-1:0] target;

  function automatic logic [WIDTH-1:0] shift_target(input logic [1:0]       op,
                                                    input logic [WIDTH-1:0] cur,
                                                    input logic             s);
    logic [WIDTH-1:0] res;
    case (op)
      OP_SHL:  res = {cur[WIDTH-2:0], s};
      OP_SHR:  res = {s, cur[WIDTH-1:1]};
      default: res = {cur[0], cur[WIDTH-1:1]};
    endcase
    return res;
  endfunction

  assign accept    = cmd_valid & cmd_ready;
  assign cmd_ready = (state == ST_IDLE) & rst;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // A zero-count shift spends one hold cycle in SHIFT so its done pulse lines up with LOAD's.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_r   <= '0;
      data_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_r   <= cmd_op;
            data_r <= cmd_data;
            cnt    <= cmd_amt;
            state  <= (cmd_op == OP_LOAD) ? ST_LOAD : ST_SHIFT;
          end
        end
        ST_LOAD: state <= ST_DONE;
        ST_SHIFT: begin
          if ((cnt == CNT_W'(1)) || (cnt == '0)) begin
            state <= ST_DONE;
          end
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    drive_en = 1'b0;
    target   = '0;
    case (state)
      ST_LOAD: begin
        drive_en = 1'b1;
        target   = data_r;
      end
      ST_SHIFT: begin
        drive_en = (cnt != '0);
        target   = shift_target(op_r, q, ser_in);
      end
      default: begin
        drive_en = 1'b0;
        target   = '0;
      end
    endcase
  end

  // Forcing a bit always uses j=t, k=~t, so j=k=1 (toggle) can never be produced.
  assign j = drive_en ? target  : '0;
  assign k = drive_en ? ~target : '0;

endmodule
